// File: rtl/jojo_vertical_ctrl.sv
// Vertical-motion sequencer for the player sprite: owns jojo_y and runs the IDLE/RISE/FALL
// machine on frame ticks, moving one pixel per step so the ground judge never misses a row.
module jojo_vertical_ctrl #(
    parameter logic [9:0] INIT_Y  = 10'd402,
    parameter logic [9:0] FLOOR_Y = 10'd402,
    parameter logic [9:0] MIN_Y   = 10'd0,
    parameter logic [3:0] JUMP_V  = 4'd8,
    parameter logic [3:0] GRAVITY = 4'd1,
    parameter logic [3:0] MAX_V   = 4'd8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       jump,
    input  logic       grounded,
    output logic [9:0] jojo_y,
    output logic       jumping_up,
    output logic       falling,
    output logic       land_pulse
);

    typedef enum logic [1:0] {IDLE, RISE, FALL} state_t;
    typedef enum logic [1:0] {MOVE, WAIT1, WAIT2} phase_t;

    state_t     state_q, state_d;
    phase_t     phase_q, phase_d;
    logic [9:0] y_q, y_d;
    logic [3:0] vel_q, vel_d;
    logic [3:0] steps_q, steps_d;
    logic       pend_q, pend_d;
    logic       land_q, land_d;
    logic       jump_q;

    logic       jump_edge;
    logic       busy;
    logic [3:0] vel_rise;
    logic [4:0] vel_sum;
    logic [3:0] vel_fall;

    // A pixel step is in flight while steps remain or a fall pixel is still in its wait phases.
    assign jump_edge = jump & ~jump_q;
    assign busy      = (steps_q != 4'd0) || (phase_q != MOVE);
    assign vel_rise  = (vel_q >= GRAVITY) ? (vel_q - GRAVITY) : 4'd0;
    assign vel_sum   = {1'b0, vel_q} + {1'b0, GRAVITY};
    assign vel_fall  = (vel_sum > {1'b0, MAX_V}) ? MAX_V : vel_sum[3:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= MOVE;
            y_q     <= INIT_Y;
            vel_q   <= 4'd0;
            steps_q <= 4'd0;
            pend_q  <= 1'b0;
            land_q  <= 1'b0;
            jump_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            y_q     <= y_d;
            vel_q   <= vel_d;
            steps_q <= steps_d;
            pend_q  <= pend_d;
            land_q  <= land_d;
            jump_q  <= jump;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        y_d     = y_q;
        vel_d   = vel_q;
        steps_d = steps_q;
        pend_d  = pend_q;
        land_d  = 1'b0;

        // Tick bookkeeping while airborne: load a step budget when free, else queue one tick.
        if (state_q != IDLE) begin
            if (!busy) begin
                if (pend_q || tick) begin
                    steps_d = vel_q;
                    pend_d  = pend_q & tick;
                end
            end else if (tick) begin
                pend_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                phase_d = MOVE;
                steps_d = 4'd0;
                pend_d  = 1'b0;
                if (!grounded) begin
                    state_d = FALL;
                    vel_d   = GRAVITY;
                end else if (jump_edge) begin
                    state_d = RISE;
                    vel_d   = JUMP_V;
                end
            end

            RISE: begin
                if (busy) begin
                    if (y_q == MIN_Y) begin
                        steps_d = 4'd0;
                        state_d = FALL;
                        vel_d   = GRAVITY;
                    end else begin
                        y_d     = y_q - 10'd1;
                        steps_d = steps_q - 4'd1;
                        if (steps_q == 4'd1) begin
                            vel_d = vel_rise;
                            if (vel_rise == 4'd0) begin
                                state_d = FALL;
                                vel_d   = GRAVITY;
                            end
                        end
                    end
                end
            end

            FALL: begin
                case (phase_q)
                    MOVE: begin
                        if (steps_q != 4'd0) begin
                            if (y_q < FLOOR_Y) begin
                                y_d = y_q + 10'd1;
                            end
                            steps_d = steps_q - 4'd1;
                            phase_d = WAIT1;
                        end
                    end
                    WAIT1: begin
                        phase_d = WAIT2;
                    end
                    WAIT2: begin
                        // By now the judge's registered flag reflects the row just entered.
                        phase_d = MOVE;
                        if (grounded || (y_q == FLOOR_Y)) begin
                            state_d = IDLE;
                            vel_d   = 4'd0;
                            steps_d = 4'd0;
                            pend_d  = 1'b0;
                            land_d  = 1'b1;
                        end else if (steps_q == 4'd0) begin
                            vel_d = vel_fall;
                        end
                    end
                    default: begin
                        phase_d = MOVE;
                    end
                endcase
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign jojo_y     = y_q;
    assign jumping_up = (state_q == RISE);
    assign falling    = (state_q == FALL);
    assign land_pulse = land_q;

endmodule
